branch_history_tracker: RTL and testbench

Speculative global-history and in-flight-branch tracker that sits opposite the pattern history table. It supplies the speculative history used to index PHT reads at fetch, records each predicted branch with its history snapshot, and on in-order resolution drives the PHT write port with `PC_actual`, `history_actual` and `is_taken_actual`. On a misprediction it repairs the history and flushes younger branches.

---
 rtl/branch_history_tracker_if.sv | 35 +++
 rtl/branch_history_tracker.sv | 121 ++++++++++++
 tb/tb_branch_history_tracker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/branch_history_tracker_if.sv
// Fetch/resolve/PHT-update bundle between the branch history tracker and its neighbours.
// master drives fetch and resolve; slave is the tracker itself.
interface branch_history_tracker_if #(
  parameter int unsigned HIST_BITS = 3,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                 fetch_valid;
  logic [15:0]          fetch_PC;
  logic                 fetch_taken_predict;
  logic                 fetch_ready;
  logic [HIST_BITS-1:0] history;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 upd_valid;
  logic [15:0]          PC_actual;
  logic [HIST_BITS-1:0] history_actual;
  logic                 is_taken_actual;
  logic                 mispredict;
  logic                 resolve_error;
  logic [CntW-1:0]      count;

  modport master (
    output fetch_valid, fetch_PC, fetch_taken_predict, resolve_valid, resolve_taken,
    input  fetch_ready, history, upd_valid, PC_actual, history_actual, is_taken_actual,
           mispredict, resolve_error, count
  );

  modport slave (
    input  fetch_valid, fetch_PC, fetch_taken_predict, resolve_valid, resolve_taken,
    output fetch_ready, history, upd_valid, PC_actual, history_actual, is_taken_actual,
           mispredict, resolve_error, count
  );
endinterface

// File: rtl/branch_history_tracker.sv
// Speculative global history plus in-order queue of predicted branches; on resolve it
// drives the PHT write port and repairs history / flushes younger branches on mispredict.
module branch_history_tracker #(
  parameter int unsigned HIST_BITS = 3,
  parameter int unsigned DEPTH     = 4
) (
  input logic                     clk,
  input logic                     rst,
  branch_history_tracker_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [15:0]          pc_mem   [DEPTH];
  logic [HIST_BITS-1:0] snap_mem [DEPTH];
  logic                 pred_mem [DEPTH];

  logic [HIST_BITS-1:0] hist_q, hist_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                 upd_q, upd_d, mis_q, mis_d, err_q, err_d;
  logic [15:0]          pc_act_q, pc_act_d;
  logic [HIST_BITS-1:0] hist_act_q, hist_act_d;
  logic                 taken_act_q, taken_act_d;

  logic [15:0]          head_pc;
  logic [HIST_BITS-1:0] head_snap;
  logic                 head_pred;
  logic                 ready, not_empty, do_pop, flush, push;

  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_snap = snap_mem[rd_ptr_q];
  assign head_pred = pred_mem[rd_ptr_q];

  assign ready     = (count_q != Full);
  assign not_empty = (count_q != '0);
  assign do_pop    = bus.resolve_valid && not_empty;
  assign flush     = do_pop && (bus.resolve_taken != head_pred);
  // A fetch in the same cycle as a mispredict is on the wrong path and is dropped.
  assign push      = bus.fetch_valid && ready && !flush;

  always_comb begin
    hist_d      = hist_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    upd_d       = do_pop;
    mis_d       = flush;
    err_d       = bus.resolve_valid && !not_empty;
    pc_act_d    = pc_act_q;
    hist_act_d  = hist_act_q;
    taken_act_d = taken_act_q;

    if (do_pop) begin
      pc_act_d    = head_pc;
      hist_act_d  = head_snap;
      taken_act_d = bus.resolve_taken;
    end

    if (flush) begin
      hist_d   = {head_snap[HIST_BITS-2:0], bus.resolve_taken};
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        hist_d   = {hist_q[HIST_BITS-2:0], bus.fetch_taken_predict};
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      upd_q       <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      pc_act_q    <= '0;
      hist_act_q  <= '0;
      taken_act_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      upd_q       <= upd_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
      pc_act_q    <= pc_act_d;
      hist_act_q  <= hist_act_d;
      taken_act_q <= taken_act_d;
    end
  end

  // Entry storage needs no reset: pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]   <= bus.fetch_PC;
      snap_mem[wr_ptr_q] <= hist_q;
      pred_mem[wr_ptr_q] <= bus.fetch_taken_predict;
    end
  end

  assign bus.fetch_ready     = ready;
  assign bus.history         = hist_q;
  assign bus.count           = count_q;
  assign bus.upd_valid       = upd_q;
  assign bus.mispredict      = mis_q;
  assign bus.resolve_error   = err_q;
  assign bus.PC_actual       = pc_act_q;
  assign bus.history_actual  = hist_act_q;
  assign bus.is_taken_actual = taken_act_q;
endmodule

// File: tb/tb_branch_history_tracker.sv
// Table-driven bench for branch_history_tracker: each vector is one cycle of stimulus
// plus the outputs expected just after the following rising edge.
module tb_branch_history_tracker;
  typedef struct {
    logic        rst;
    logic        fv;
    logic [15:0] pc;
    logic        pred;
    logic        rv;
    logic        rt;
    logic [2:0]  h;
    logic [2:0]  c;
    logic        rdy;
    logic        upd;
    logic        mis;
    logic        err;
    logic [15:0] pca;
    logic [2:0]  ha;
    logic        tk;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_history_tracker_if #(.HIST_BITS(3), .DEPTH(4)) bus ();

  branch_history_tracker #(.HIST_BITS(3), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic fv, logic [15:0] pc, logic pred, logic rv,
                              logic rt, logic [2:0] h, logic [2:0] c, logic rdy, logic upd,
                              logic mis, logic err, logic [15:0] pca, logic [2:0] ha,
                              logic tk);
    vec_t v;
    v.rst = r;  v.fv = fv;  v.pc = pc;   v.pred = pred; v.rv = rv;   v.rt = rt;
    v.h = h;    v.c = c;    v.rdy = rdy; v.upd = upd;   v.mis = mis; v.err = err;
    v.pca = pca; v.ha = ha; v.tk = tk;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    rst                     = v.rst;
    bus.fetch_valid         = v.fv;
    bus.fetch_PC            = v.pc;
    bus.fetch_taken_predict = v.pred;
    bus.resolve_valid       = v.rv;
    bus.resolve_taken       = v.rt;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_vec++;
    if (bus.history !== e.h || bus.count !== e.c || bus.fetch_ready !== e.rdy ||
        bus.upd_valid !== e.upd || bus.mispredict !== e.mis || bus.resolve_error !== e.err ||
        bus.PC_actual !== e.pca || bus.history_actual !== e.ha ||
        bus.is_taken_actual !== e.tk) begin
      n_bad++;
      $display("FAIL %s: got hist=%b cnt=%0d rdy=%b upd=%b mis=%b err=%b pc=%h ha=%b tk=%b; want hist=%b cnt=%0d rdy=%b upd=%b mis=%b err=%b pc=%h ha=%b tk=%b",
               name, bus.history, bus.count, bus.fetch_ready, bus.upd_valid, bus.mispredict,
               bus.resolve_error, bus.PC_actual, bus.history_actual, bus.is_taken_actual,
               e.h, e.c, e.rdy, e.upd, e.mis, e.err, e.pca, e.ha, e.tk);
    end
  endtask

  initial begin
    bus.fetch_valid         = 1'b0;
    bus.fetch_PC            = '0;
    bus.fetch_taken_predict = 1'b0;
    bus.resolve_valid       = 1'b0;
    bus.resolve_taken       = 1'b0;

    //                rst fv pc       pd rv rt  h  c rdy upd mis err pca      ha tk
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0044, 0, 0, 0, 2, 2, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0048, 1, 0, 0, 5, 3, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 5, 2, 1, 1, 0, 0, 16'h0040, 0, 1));
    // Mispredict with a wrong-path fetch in the same cycle.
    tbl.push_back(mk(0, 1, 16'h0050, 1, 1, 1, 3, 0, 1, 1, 1, 0, 16'h0044, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 3, 0, 1, 0, 0, 0, 16'h0044, 1, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0100, 1, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0104, 0, 0, 0, 2, 2, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0108, 1, 0, 0, 5, 3, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h010C, 1, 0, 0, 3, 4, 0, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0110, 0, 0, 0, 3, 4, 0, 0, 0, 0, 16'h0000, 0, 0));
    // Full queue: correct resolve pops, the fetch is refused.
    tbl.push_back(mk(0, 1, 16'h0114, 0, 1, 1, 3, 3, 1, 1, 0, 0, 16'h0100, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 3, 2, 1, 1, 0, 0, 16'h0104, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 4, 0, 1, 1, 1, 0, 16'h0108, 2, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 4, 0, 1, 0, 0, 1, 16'h0108, 2, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 4, 0, 1, 0, 0, 0, 16'h0108, 2, 0));
    tbl.push_back(mk(0, 1, 16'h0200, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0108, 2, 0));
    tbl.push_back(mk(0, 1, 16'h0204, 1, 0, 0, 1, 2, 1, 0, 0, 0, 16'h0108, 2, 0));
    // Reset wins over a resolve in the same cycle.
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Correct resolve with a simultaneous fetch: push and pop, count unchanged.
    step(mk(0, 1, 16'h0300, 1, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 0, 0), "pp_fetch");
    step(mk(0, 1, 16'h0304, 0, 1, 1, 2, 1, 1, 1, 0, 0, 16'h0300, 0, 1), "pp_pushpop");
    step(mk(0, 0, 16'h0000, 0, 1, 0, 2, 0, 1, 1, 0, 0, 16'h0304, 1, 0), "pp_drain");
    step(mk(0, 0, 16'h0000, 0, 0, 0, 2, 0, 1, 0, 0, 0, 16'h0304, 1, 0), "pp_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
